// File: rtl/fir_pkg.sv
// Shared types and helpers for the complex FIR decimating summer.
package fir_pkg;

  typedef enum logic [1:0] {
    SHIFT = 2'd0,
    SUM   = 2'd1,
    OUT   = 2'd2
  } state_t;

  // Accumulator must absorb NUM_TAPS additions of DATA_WIDTH values without overflow.
  function automatic int acc_width(input int data_width, input int num_taps);
    return data_width + $clog2(num_taps);
  endfunction

endpackage

// File: rtl/fir_complex_sum_decim.sv
// Counts DECIM shifts of the tap chain, then sums the held tap products one per cycle
// for I and Q and writes the wrapped DATA_WIDTH result to the output FIFO.
module fir_complex_sum_decim
  import fir_pkg::*;
#(
  parameter int NUM_TAPS   = 20,
  parameter int DATA_WIDTH = 32,
  parameter int DECIM      = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           in_empty,
  output logic                           tap_shift,
  input  logic [NUM_TAPS*DATA_WIDTH-1:0] tap_real_in,
  input  logic [NUM_TAPS*DATA_WIDTH-1:0] tap_imag_in,
  input  logic                           out_full,
  output logic                           out_wr_en,
  output logic [DATA_WIDTH-1:0]          out_real,
  output logic [DATA_WIDTH-1:0]          out_imag
);

  localparam int ACC_W = acc_width(DATA_WIDTH, NUM_TAPS);
  localparam int IDX_W = $clog2(NUM_TAPS);
  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int EXT_W = ACC_W - DATA_WIDTH;
  localparam logic [IDX_W-1:0] LAST_TAP    = IDX_W'(NUM_TAPS - 1);
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(DECIM - 1);

  state_t state, state_next;
  logic [CNT_W-1:0]      sample_cnt;
  logic [IDX_W-1:0]      tap_idx;
  logic [ACC_W-1:0]      acc_r, acc_i;
  logic [ACC_W-1:0]      sum_r, sum_i;
  logic [DATA_WIDTH-1:0] tap_r, tap_i;

  assign tap_r = tap_real_in[tap_idx*DATA_WIDTH +: DATA_WIDTH];
  assign tap_i = tap_imag_in[tap_idx*DATA_WIDTH +: DATA_WIDTH];
  assign sum_r = acc_r + {{EXT_W{tap_r[DATA_WIDTH-1]}}, tap_r};
  assign sum_i = acc_i + {{EXT_W{tap_i[DATA_WIDTH-1]}}, tap_i};

  // Strobes are gated by reset so nothing leaves the block during the reset cycle.
  always_comb begin
    state_next = state;
    tap_shift  = 1'b0;
    out_wr_en  = 1'b0;
    if (!reset) begin
      case (state)
        SHIFT: begin
          tap_shift = !in_empty;
          if (!in_empty && sample_cnt == LAST_SAMPLE) state_next = SUM;
        end
        SUM: begin
          if (tap_idx == LAST_TAP) state_next = OUT;
        end
        OUT: begin
          out_wr_en = !out_full;
          if (!out_full) state_next = SHIFT;
        end
        default: state_next = SHIFT;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= SHIFT;
      sample_cnt <= '0;
      tap_idx    <= '0;
      acc_r      <= '0;
      acc_i      <= '0;
      out_real   <= '0;
      out_imag   <= '0;
    end else begin
      state <= state_next;
      case (state)
        SHIFT: begin
          if (tap_shift) begin
            if (sample_cnt == LAST_SAMPLE) begin
              sample_cnt <= '0;
              tap_idx    <= '0;
              acc_r      <= '0;
              acc_i      <= '0;
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
        end
        SUM: begin
          acc_r <= sum_r;
          acc_i <= sum_i;
          if (tap_idx == LAST_TAP) begin
            tap_idx  <= '0;
            out_real <= sum_r[DATA_WIDTH-1:0];
            out_imag <= sum_i[DATA_WIDTH-1:0];
          end else begin
            tap_idx <= tap_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_complex_sum_decim.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level
// behavioural model of shift counting, summing delay and output handshake.
module tb_fir_complex_sum_decim;

  localparam int NT  = 4;
  localparam int DW  = 32;
  localparam int DEC = 2;

  logic               clock;
  logic               reset;
  logic               in_empty;
  logic               tap_shift;
  logic [NT*DW-1:0]   tap_real_in;
  logic [NT*DW-1:0]   tap_imag_in;
  logic               out_full;
  logic               out_wr_en;
  logic [DW-1:0]      out_real;
  logic [DW-1:0]      out_imag;

  logic [DW-1:0] tr [NT];
  logic [DW-1:0] ti [NT];

  int checks = 0;
  int errors = 0;

  int cnt = 0;
  int busy = 0;
  bit wait_out = 0;
  bit shifted_prev = 0;
  bit rand_taps = 0;
  logic [DW-1:0] exp_r = '0, exp_i = '0, pend_r = '0, pend_i = '0;
  int cyc = 0;
  int wr_count = 0;
  int shift_count = 0;
  int prev_wr_cyc = -1;
  int spacing = 0;
  logic [DW-1:0] last_wr_r = '0, last_wr_i = '0;

  fir_complex_sum_decim #(
    .NUM_TAPS  (NT),
    .DATA_WIDTH(DW),
    .DECIM     (DEC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_empty   (in_empty),
    .tap_shift  (tap_shift),
    .tap_real_in(tap_real_in),
    .tap_imag_in(tap_imag_in),
    .out_full   (out_full),
    .out_wr_en  (out_wr_en),
    .out_real   (out_real),
    .out_imag   (out_imag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    tap_real_in = '0;
    tap_imag_in = '0;
    for (int k = 0; k < NT; k++) begin
      tap_real_in[k*DW +: DW] = tr[k];
      tap_imag_in[k*DW +: DW] = ti[k];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic setTaps(input logic [DW-1:0] r0, r1, r2, r3, input logic [DW-1:0] iv);
    tr[0] = r0; tr[1] = r1; tr[2] = r2; tr[3] = r3;
    for (int k = 0; k < NT; k++) ti[k] = iv;
  endtask

  // One clock cycle: drive, compare at the falling edge, then advance the model.
  task automatic applyStimulus(input bit rst, input bit empty, input bit full);
    bit ts_exp, wr_exp;
    reset    = rst;
    in_empty = empty;
    out_full = full;
    if (shifted_prev && rand_taps) begin
      for (int k = 0; k < NT; k++) begin
        tr[k] = $urandom;
        ti[k] = $urandom;
      end
    end
    @(negedge clock);
    ts_exp = !rst && busy == 0 && !wait_out && !empty;
    wr_exp = !rst && wait_out && !full;
    if (!rst && busy == NT) begin
      pend_r = '0;
      pend_i = '0;
      for (int k = 0; k < NT; k++) begin
        pend_r = pend_r + tr[k];
        pend_i = pend_i + ti[k];
      end
    end
    checkOutput("tap_shift", {31'b0, tap_shift}, {31'b0, ts_exp});
    checkOutput("out_wr_en", {31'b0, out_wr_en}, {31'b0, wr_exp});
    if (!rst) begin
      checkOutput("out_real", out_real, exp_r);
      checkOutput("out_imag", out_imag, exp_i);
    end
    if (tap_shift) shift_count++;
    if (out_wr_en) begin
      wr_count++;
      last_wr_r = out_real;
      last_wr_i = out_imag;
      if (prev_wr_cyc >= 0) spacing = cyc - prev_wr_cyc;
      prev_wr_cyc = cyc;
    end
    if (rst) begin
      cnt = 0; busy = 0; wait_out = 0; exp_r = '0; exp_i = '0;
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) begin
        wait_out = 1;
        exp_r = pend_r;
        exp_i = pend_i;
      end
    end else if (wait_out) begin
      if (!full) wait_out = 0;
    end else if (ts_exp) begin
      cnt++;
      if (cnt == DEC) begin
        cnt = 0;
        busy = NT;
      end
    end
    shifted_prev = ts_exp;
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic drainToShift(input string tag);
    int n = 0;
    while ((busy != 0 || wait_out || cnt != 0) && n < 40) begin
      applyStimulus(0, 0, 0);
      n++;
    end
    checkOutput(tag, {31'b0, (busy == 0 && !wait_out && cnt == 0)}, 32'd1);
  endtask

  initial begin
    int n, base, shifts_before;
    reset = 1'b1; in_empty = 1'b0; out_full = 1'b0;
    setTaps(32'd1, 32'd2, 32'd3, 32'd4, 32'hFFFFFFFF);

    // Reset held three cycles with samples available.
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0);
    checkOutput("rst_out_real", out_real, 32'd0);
    checkOutput("rst_out_imag", out_imag, 32'd0);

    // Basic decimated sum and output period.
    wr_count = 0; prev_wr_cyc = -1;
    for (int i = 0; i < 14; i++) applyStimulus(0, 0, 0);
    checkOutput("t2_writes", 32'(wr_count), 32'd2);
    checkOutput("t2_period", 32'(spacing), 32'd7);
    checkOutput("t2_real", last_wr_r, 32'd10);
    checkOutput("t2_imag", last_wr_i, 32'hFFFFFFFC);

    // Output FIFO full when OUT is entered.
    n = 0;
    while (!wait_out && n < 20) begin applyStimulus(0, 0, 0); n++; end
    checkOutput("t3_reach_out", {31'b0, wait_out}, 32'd1);
    base = wr_count;
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1);
    checkOutput("t3_held", 32'(wr_count - base), 32'd0);
    applyStimulus(0, 0, 0);
    checkOutput("t3_release", 32'(wr_count - base), 32'd1);
    applyStimulus(0, 0, 0);

    // Gaps in the input stream.
    drainToShift("t4_drain");
    shifts_before = shift_count;
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);
    checkOutput("t4_shifts", 32'(shift_count - shifts_before), 32'd2);
    checkOutput("t4_in_sum", 32'(busy), 32'(NT));
    applyStimulus(0, 0, 0);

    // Full-scale taps wrap modulo 2^32.
    drainToShift("t5_drain");
    setTaps(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000);
    for (int i = 0; i < 14; i++) applyStimulus(0, 0, 0);
    checkOutput("t5_real", last_wr_r, 32'hFFFFFFFC);
    checkOutput("t5_imag", last_wr_i, 32'h00000000);

    // Reset in the second SUM cycle aborts the partial result.
    n = 0;
    while (busy != NT - 1 && n < 20) begin applyStimulus(0, 0, 0); n++; end
    checkOutput("t6_reach_sum", 32'(busy), 32'(NT - 1));
    base = wr_count;
    applyStimulus(1, 0, 0);
    setTaps(32'd5, 32'd6, 32'd7, 32'd8, 32'hFFFFFFFE);
    for (int i = 0; i < 14; i++) applyStimulus(0, 0, 0);
    checkOutput("t6_writes", 32'(wr_count - base), 32'd2);
    checkOutput("t6_real", last_wr_r, 32'd26);
    checkOutput("t6_imag", last_wr_i, 32'hFFFFFFF8);

    // Random traffic with changing taps, stalls and occasional resets.
    rand_taps = 1;
    for (int i = 0; i < 600; i++)
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 2) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
